uart_cmd_wrapper: RTL
=====================

Name: uart_cmd_wrapper

Overview:
Receive side of the remote command link. Deserialises the 2-byte command stream that the remote command sender transmits (high byte first), and assembles it into a 16-bit cmd with a cmd_rdy/clr_cmd_rdy handshake for the command processor. It also serialises the 8-bit response byte back over TX. It sits between the RX/TX pins and the command processor.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); minimum 8
GAP_TIMEOUT, 2^20, clocks allowed between end of high byte and end of low byte before the partial command is discarded

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
RX  input  1  serial in, idle high, asynchronous to clk
TX  output  1  serial out, idle high
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  valid command held in cmd
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  8  response byte to send
trmt  input  1  start transmission of resp
tx_done  output  1  response frame complete
cmd_dropped  output  1  1-cycle pulse: partial command discarded (timeout or framing error)
frame_err  output  1  1-cycle pulse: received stop bit sampled 0

Behaviour:
- Reset state: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, cmd_dropped=0, frame_err=0, FSM=IDLE. RX synchroniser flops preset to 1, so no false start bit is detected after reset.
- Frame format is 8N1, LSB first.
- RX path:
  - RX passes through a 2-flop synchroniser.
  - A falling edge in receiver idle starts a frame. The bit counter loads BAUD_DIV/2, so sampling happens mid-bit.
  - Each bit is then sampled every BAUD_DIV clocks: start, 8 data bits, stop.
  - At the stop sample (cycle N), byte_valid pulses if stop=1. If stop=0, frame_err pulses and the byte is discarded.
  - The receiver re-arms in the cycle after the stop sample.
  - The start bit is not re-validated.
- Assembly FSM, states IDLE and WAIT_LOW:
  - IDLE + byte_valid: latch high byte, clear cmd_rdy, clear gap counter, go to WAIT_LOW.
  - WAIT_LOW + byte_valid: cmd <= {high, byte} and cmd_rdy <= 1 at cycle N+1, go to IDLE.
  - WAIT_LOW + gap counter reaching GAP_TIMEOUT: cmd_dropped pulses, go to IDLE. cmd and cmd_rdy are unchanged.
  - WAIT_LOW + frame_err: cmd_dropped pulses, go to IDLE.
  - IDLE + frame_err: only frame_err pulses; cmd_dropped stays 0.
- cmd_rdy:
  - Set on assembly; cleared on clr_cmd_rdy or on arrival of a new high byte.
  - If set and clear occur in the same cycle, set wins.
  - cmd is stable while cmd_rdy=1 and also stays stable after cmd_rdy clears. It changes only on assembly.
- Gap counter: saturating, counts only in WAIT_LOW, sized clog2(GAP_TIMEOUT+1).
- TX path:
  - trmt in tx idle loads {1, resp, 0} into a shift register and clears tx_done.
  - TX drives start, data[0..7], stop; each bit lasts BAUD_DIV clocks.
  - tx_done sets after the stop bit's full period (10*BAUD_DIV clocks after trmt) and holds until the next accepted trmt.
  - trmt while busy is ignored; resp is sampled only on accepted trmt.
- RX and TX operate fully independently (full duplex).
- rst mid-frame aborts both paths immediately: TX=1 and any partial command is discarded.

Decomposition:
- Package uart_cmd_pkg: typedef enum logic {IDLE, WAIT_LOW} asm_state_t; localparams for frame bit count (10) and data bits (8).
- One sub-module, uart_trx: 8N1 serialiser/deserialiser with BAUD_DIV parameter and active-high async reset. Port names: byte_valid, frame_err, rx_byte, tx_data, trmt, tx_done.
- uart_cmd_wrapper contains the assembly FSM, gap counter and cmd/cmd_rdy registers.

Test Plan:
All tests use BAUD_DIV=16 and GAP_TIMEOUT=400.
1. Send bytes 8'hA5 then 8'h3C -> cmd=16'hA53C; cmd_rdy rises 1 cycle after the second stop-bit sample; no cmd_dropped.
2. After test 1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd remains 16'hA53C. Send 8'h12 -> cmd_rdy stays 0 before the low byte.
3. Send 8'h12, idle 500 clocks, then send 8'h34, 8'h56 -> single cmd_dropped pulse ~400 clocks after 8'h12 completes; final cmd=16'h3456, cmd_rdy=1.
4. trmt with resp=8'hA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 (16 clocks each); tx_done=1 at 160 clocks. A second trmt at clock 50 is ignored.
5. Send 8'h80 with stop bit forced 0 as the high byte -> frame_err pulse, FSM stays IDLE, no cmd_dropped. Then send 8'hBE, 8'hEF -> cmd=16'hBEEF.
6. Assert rst mid-way through the low byte and mid TX frame -> TX=1, cmd_rdy=0, cmd=0. After release, 8'hCA, 8'hFE -> cmd=16'hCAFE.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and frame constants for the remote command link receiver/transmitter.
package uart_cmd_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } asm_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_trx.sv
// 8N1 serialiser/deserialiser, LSB first, BAUD_DIV clocks per bit.
module uart_trx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic [DATA_BITS-1:0] rx_byte,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 trmt,
  output logic                 tx_done
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]    FIRST_DAT = 4'd1;
  localparam logic [3:0]    LAST_DAT  = 4'(DATA_BITS);

  logic                  rx_meta_q, rx_sync_q, rx_prev_q, rx_busy_q;
  logic [CW-1:0]         rx_baud_q;
  logic [3:0]            rx_bit_q;
  logic [DATA_BITS-1:0]  rx_shift_q;
  logic                  rx_stop;

  logic                  tx_busy_q, tx_done_q;
  logic [CW-1:0]         tx_baud_q;
  logic [3:0]            tx_bit_q;
  logic [FRAME_BITS-1:0] tx_shift_q;

  // Sync flops preset high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_baud_q <= BAUD_HALF;
          rx_bit_q  <= '0;
        end
      end else if (rx_baud_q == '0) begin
        rx_baud_q <= BAUD_LAST;
        rx_bit_q  <= rx_bit_q + 4'd1;
        if (rx_bit_q >= FIRST_DAT && rx_bit_q <= LAST_DAT)
          rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT)
          rx_busy_q <= 1'b0;
      end else begin
        rx_baud_q <= rx_baud_q - CW'(1);
      end
    end
  end

  assign rx_stop    = rx_busy_q && (rx_baud_q == '0) && (rx_bit_q == LAST_BIT);
  assign byte_valid = rx_stop && rx_sync_q;
  assign frame_err  = rx_stop && !rx_sync_q;
  assign rx_byte    = rx_shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_q  <= 1'b1;
        tx_done_q  <= 1'b0;
        tx_shift_q <= {1'b1, tx_data, 1'b0};
        tx_baud_q  <= BAUD_LAST;
        tx_bit_q   <= '0;
      end
    end else if (tx_baud_q == '0) begin
      if (tx_bit_q == LAST_BIT) begin
        tx_busy_q <= 1'b0;
        tx_done_q <= 1'b1;
      end else begin
        tx_shift_q <= {1'b1, tx_shift_q[FRAME_BITS-1:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
        tx_baud_q  <= BAUD_LAST;
      end
    end else begin
      tx_baud_q <= tx_baud_q - CW'(1);
    end
  end

  assign tx      = tx_shift_q[0] | ~tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command; sends response bytes.
// state    | meaning
// IDLE     | waiting for the high byte of a command
// WAIT_LOW | high byte held, waiting for low byte under gap timeout
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV    = 2604,
  parameter int GAP_TIMEOUT = 2 ** 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        cmd_dropped,
  output logic        frame_err
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TIMEOUT);

  logic                 byte_valid, rx_frame_err;
  logic [DATA_BITS-1:0] rx_byte;

  asm_state_t           state_q, state_d;
  logic [DATA_BITS-1:0] high_q, high_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 cmd_rdy_q, cmd_rdy_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 dropped;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .tx         (TX),
    .byte_valid (byte_valid),
    .frame_err  (rx_frame_err),
    .rx_byte    (rx_byte),
    .tx_data    (resp),
    .trmt       (trmt),
    .tx_done    (tx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      gap_q     <= gap_d;
    end
  end

  // Assembly is evaluated after the acknowledge so a same-cycle set wins.
  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    gap_d     = gap_q;
    dropped   = 1'b0;
    if (state_q == WAIT_LOW && gap_q != GAP_MAX)
      gap_d = gap_q + GW'(1);
    if (clr_cmd_rdy)
      cmd_rdy_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_valid) begin
          high_d    = rx_byte;
          cmd_rdy_d = 1'b0;
          gap_d     = '0;
          state_d   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (byte_valid) begin
          cmd_d     = {high_q, rx_byte};
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end else if (rx_frame_err || gap_q == GAP_MAX) begin
          dropped = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign cmd_dropped = dropped;
  assign frame_err   = rx_frame_err;

endmodule
